npu_fifo_reader: RTL and testbench
==================================

Name: npu_fifo_reader

Overview:
Host-side reader for the NPU output FIFO. It pops bytes through the FIFO read port and pairs them, high byte first, into 16-bit results. Each result is presented on a valid/ready interface with frame delimiting.
- Drain-end counterpart of the NPU controller's FIFO write path. Attaches to out_fifo rd_en/data_out/empty.
- The FIFO has a registered read: data_out is valid exactly 1 cycle after a cycle with rd_en=1.

Parameters:
WORDS_PER_FRAME, 4, 16-bit results per frame; range 1..256; RES_LAST marks the final one.
FRAME_CNT_W, 8, width of the completed-frame counter.

Ports:
CLKEXT  in  1  clock, rising edge.
RST_GLO  in  1  reset, asynchronous, active-high.
EN_RD  in  1  level enable; while 0, no new word is started.
FLUSH  in  1  synchronous abort to IDLE; has priority over all other inputs except RST_GLO.
FIFO_EMPTY  in  1  FIFO empty flag.
FIFO_DATA  in  8  FIFO data_out.
FIFO_RD_EN  out  1  FIFO pop strobe; combinational from state and FIFO_EMPTY.
RES_DATA  out  16  assembled result, {hi, lo}.
RES_VALID  out  1  result available.
RES_READY  in  1  consumer accepts; handshake = RES_VALID & RES_READY.
RES_LAST  out  1  valid with RES_VALID; final word of frame.
FRAME_CNT  out  FRAME_CNT_W  completed frames, wraps to 0.
BUSY  out  1  state != IDLE.
ERR_ODD  out  1  sticky: FLUSH discarded a captured high byte.

Behaviour:
- Reset values: state IDLE; RES_DATA 0; RES_VALID 0; RES_LAST 0; FRAME_CNT 0; word counter 0; hi register 0; ERR_ODD 0. FIFO_RD_EN is 0 in IDLE.
- States: IDLE, RD_HI, CAP_HI, RD_LO, CAP_LO, PRESENT.
- IDLE: if EN_RD -> RD_HI.
- RD_HI: FIFO_RD_EN = ~FIFO_EMPTY. If a pop occurs -> CAP_HI; else stay (stall, no pop).
- CAP_HI: hi <= FIFO_DATA -> RD_LO.
- RD_LO: FIFO_RD_EN = ~FIFO_EMPTY. Pop -> CAP_LO; else stay. Does not re-check EN_RD; a started word always completes.
- CAP_LO: RES_DATA <= {hi, FIFO_DATA}; RES_VALID <= 1; RES_LAST <= (word_cnt == WORDS_PER_FRAME-1) -> PRESENT.
- PRESENT: RES_DATA, RES_VALID and RES_LAST hold stable until the handshake. No FIFO_RD_EN here (no prefetch).
- On handshake: RES_VALID <= 0; RES_LAST <= 0.
  - If RES_LAST: word_cnt <= 0 and FRAME_CNT <= FRAME_CNT+1 (mod 2^FRAME_CNT_W).
  - Else: word_cnt <= word_cnt+1.
  - Next state: RD_HI if EN_RD, else IDLE.
- Latency, FIFO nonempty and RES_READY=1:
  - First FIFO_RD_EN 1 cycle after EN_RD is sampled in IDLE.
  - RES_VALID rises 4 cycles after the first pop.
  - Steady-state throughput: one result per 5 cycles.
- FIFO_RD_EN is never asserted when FIFO_EMPTY=1 and never asserted outside RD_HI/RD_LO. Exactly 2 pops per result.
- FLUSH in any state: next state IDLE; RES_VALID, RES_LAST and word_cnt cleared; FIFO_RD_EN forced 0 that cycle.
  - If the state was CAP_HI, RD_LO or CAP_LO, set ERR_ODD=1. A byte popped in the flush cycle's predecessor is discarded.
  - FRAME_CNT is unaffected.
- FLUSH and a handshake in the same cycle: FLUSH wins; the word is treated as accepted but counters are cleared per FLUSH.
- ERR_ODD clears only on RST_GLO.
- RST_GLO mid-operation: immediate return to reset values; no pop is issued on the cycle after reset release.

Decomposition:
- Shared NPU package (npu_pkg constants file): reader state encodings (3-bit), FIFO read latency constant RD_LAT=1, NPU byte width 8.
- No sub-module needed. The FSM, word/frame counters and output register live in one module (~180 lines).

Test Plan:
- Basic: FIFO holds 0x12, 0x34; EN_RD=1; RES_READY=1 -> RES_DATA=0x1234, RES_VALID for 1 cycle, exactly 2 FIFO_RD_EN pulses, RES_LAST=0, FRAME_CNT=0.
- Empty stall: FIFO holds 0xAB only, EN_RD=1; push 0xCD 6 cycles later -> FIFO_RD_EN stays 0 while empty, no pop while empty, then RES_DATA=0xABCD.
- Backpressure: RES_READY=0 for 3 cycles while RES_VALID=1 -> RES_DATA stable, FIFO_RD_EN=0 throughout; accepted on the 4th cycle.
- Frame: 8 bytes 0x01..0x08, WORDS_PER_FRAME=4 -> results 0x0102, 0x0304, 0x0506, 0x0708, RES_LAST only on 0x0708, FRAME_CNT=1. Repeat 256 frames -> FRAME_CNT wraps to 0.
- Flush: FLUSH asserted in RD_LO after 0x55 captured -> IDLE next cycle, ERR_ODD=1, RES_VALID=0, word_cnt=0. A subsequent 2-byte word assembles correctly.
- Reset mid-op: RST_GLO pulsed during PRESENT -> all outputs at reset values asynchronously; EN_RD=0 afterward -> no FIFO_RD_EN.

Source files
------------

// File: rtl/npu_fifo_reader_pkg.sv
// ---------------------------------------------------------------------------
// npu_fifo_reader_pkg
//
// Purpose:
//   Shared constants and types for the NPU output-FIFO reader. Holds the
//   reader state encoding, the byte/result widths and the FIFO read latency.
//
// Contents:
//   RD_LAT      - cycles from a FIFO pop (rd_en=1) to valid data_out
//   NPU_BYTE_W  - width of one FIFO entry
//   RES_W       - width of an assembled result (two bytes, high first)
//   rdState_t   - 3-bit reader FSM state encoding
//   holdsHiByte - true in states where a high byte has been popped but the
//                 matching low byte has not yet been folded into a result
// ---------------------------------------------------------------------------
package npu_fifo_reader_pkg;

  localparam int RD_LAT     = 1;
  localparam int NPU_BYTE_W = 8;
  localparam int RES_W      = 2 * NPU_BYTE_W;

  // Each pop state (RD_*) is followed by exactly one capture state (CAP_*),
  // which is where the registered FIFO output becomes valid (RD_LAT = 1).
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_HI   = 3'd1,
    ST_CAP_HI  = 3'd2,
    ST_RD_LO   = 3'd3,
    ST_CAP_LO  = 3'd4,
    ST_PRESENT = 3'd5
  } rdState_t;

  // A high byte is "in flight" from the moment it is captured until the low
  // byte has been captured; aborting in this window loses half a word.
  function automatic logic holdsHiByte(input rdState_t s);
    return (s == ST_CAP_HI) || (s == ST_RD_LO) || (s == ST_CAP_LO);
  endfunction

endpackage

// File: rtl/npu_fifo_reader_if.sv
// ---------------------------------------------------------------------------
// npu_fifo_reader_if
//
// Purpose:
//   Bundles the two buses of the FIFO reader: the read port of the NPU
//   output FIFO and the valid/ready result stream toward the host.
//
// Signals:
//   FIFO_EMPTY  FIFO empty flag                      (FIFO -> reader)
//   FIFO_DATA   FIFO registered data_out, 8 bits     (FIFO -> reader)
//   FIFO_RD_EN  FIFO pop strobe                      (reader -> FIFO)
//   RES_DATA    assembled 16-bit result {hi, lo}     (reader -> consumer)
//   RES_VALID   result available                     (reader -> consumer)
//   RES_LAST    final result of a frame              (reader -> consumer)
//   RES_READY   consumer accepts the result          (consumer -> reader)
//
// Modports:
//   master - the reader itself
//   slave  - the FIFO/consumer side (testbench or surrounding system)
// ---------------------------------------------------------------------------
interface npu_fifo_reader_if;
  import npu_fifo_reader_pkg::*;

  logic                  FIFO_EMPTY;
  logic [NPU_BYTE_W-1:0] FIFO_DATA;
  logic                  FIFO_RD_EN;
  logic [RES_W-1:0]      RES_DATA;
  logic                  RES_VALID;
  logic                  RES_LAST;
  logic                  RES_READY;

  modport master (
    input  FIFO_EMPTY,
    input  FIFO_DATA,
    input  RES_READY,
    output FIFO_RD_EN,
    output RES_DATA,
    output RES_VALID,
    output RES_LAST
  );

  modport slave (
    output FIFO_EMPTY,
    output FIFO_DATA,
    output RES_READY,
    input  FIFO_RD_EN,
    input  RES_DATA,
    input  RES_VALID,
    input  RES_LAST
  );

endinterface

// File: rtl/npu_fifo_reader.sv
// ---------------------------------------------------------------------------
// npu_fifo_reader
//
// Purpose:
//   Host-side drain of the NPU output FIFO. Pops bytes through the FIFO read
//   port, pairs them high byte first into 16-bit results and presents each
//   result on a valid/ready stream, tagging the last result of every frame
//   of WORDS_PER_FRAME results. Counts completed frames and flags a flush
//   that threw away a half-assembled word.
//
// Parameters:
//   WORDS_PER_FRAME  results per frame (1..256)
//   FRAME_CNT_W      width of the completed-frame counter
//
// Ports:
//   CLKEXT     in   clock, rising edge
//   RST_GLO    in   asynchronous active-high reset
//   EN_RD      in   level enable; while low no new word is started
//   FLUSH      in   synchronous abort to IDLE, beats everything but reset
//   rdBus      if   FIFO read port + result stream (master modport)
//   FRAME_CNT  out  completed frames, wraps to 0
//   BUSY       out  FSM not in IDLE
//   ERR_ODD    out  sticky: a flush discarded a captured high byte
// ---------------------------------------------------------------------------
module npu_fifo_reader
  import npu_fifo_reader_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 4,
  parameter int FRAME_CNT_W     = 8
) (
  input  logic                   CLKEXT,
  input  logic                   RST_GLO,
  input  logic                   EN_RD,
  input  logic                   FLUSH,
  npu_fifo_reader_if.master      rdBus,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT,
  output logic                   BUSY,
  output logic                   ERR_ODD
);

  // Word counter only has to reach WORDS_PER_FRAME-1; keep it at least 1 bit.
  localparam int WCNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(WORDS_PER_FRAME - 1);

  rdState_t               r_state;
  rdState_t               w_nextState;
  logic                   w_pop;
  logic                   w_handshake;
  logic [WCNT_W-1:0]      r_wordCnt;
  logic [NPU_BYTE_W-1:0]  r_hi;
  logic [RES_W-1:0]       r_resData;
  logic                   r_resValid;
  logic                   r_resLast;
  logic [FRAME_CNT_W-1:0] r_frameCnt;
  logic                   r_errOdd;

  // A result only leaves when the consumer takes it; valid is only ever
  // raised in PRESENT, so this cannot fire in any other state.
  assign w_handshake = r_resValid & rdBus.RES_READY;

  // Next-state and pop decode. A pop is only requested in the two read
  // states and only when the FIFO has data, so an empty FIFO simply stalls
  // the FSM in place. FLUSH overrides everything and suppresses the pop so
  // no byte is pulled out of the FIFO on the abort cycle itself.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    if (FLUSH) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (EN_RD) w_nextState = ST_RD_HI;
        end
        ST_RD_HI: begin
          w_pop = ~rdBus.FIFO_EMPTY;
          if (w_pop) w_nextState = ST_CAP_HI;
        end
        ST_CAP_HI: begin
          w_nextState = ST_RD_LO;
        end
        ST_RD_LO: begin
          // A started word always completes, so EN_RD is not looked at here.
          w_pop = ~rdBus.FIFO_EMPTY;
          if (w_pop) w_nextState = ST_CAP_LO;
        end
        ST_CAP_LO: begin
          w_nextState = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (w_handshake) w_nextState = EN_RD ? ST_RD_HI : ST_IDLE;
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  // State register. Reset lands in IDLE, which never pops, so the first
  // cycle after reset release cannot touch the FIFO.
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: byte capture, result register, word/frame counters and the
  // sticky odd-byte error. The capture states sit one cycle after the pop
  // because the FIFO output is registered. On FLUSH the pending result and
  // the word position are dropped, but the frame count is left alone; if
  // the flush also coincides with a handshake, the flush clearing wins.
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_hi       <= '0;
      r_resData  <= '0;
      r_resValid <= 1'b0;
      r_resLast  <= 1'b0;
      r_wordCnt  <= '0;
      r_frameCnt <= '0;
      r_errOdd   <= 1'b0;
    end else if (FLUSH) begin
      r_resValid <= 1'b0;
      r_resLast  <= 1'b0;
      r_wordCnt  <= '0;
      if (holdsHiByte(r_state)) r_errOdd <= 1'b1;
    end else begin
      if (r_state == ST_CAP_HI) begin
        r_hi <= rdBus.FIFO_DATA;
      end
      if (r_state == ST_CAP_LO) begin
        r_resData  <= {r_hi, rdBus.FIFO_DATA};
        r_resValid <= 1'b1;
        r_resLast  <= (r_wordCnt == LAST_IDX);
      end
      if (w_handshake) begin
        r_resValid <= 1'b0;
        r_resLast  <= 1'b0;
        if (r_resLast) begin
          r_wordCnt  <= '0;
          r_frameCnt <= r_frameCnt + 1'b1;
        end else begin
          r_wordCnt  <= r_wordCnt + 1'b1;
        end
      end
    end
  end

  // Output mapping. The pop strobe stays combinational so the FIFO sees it
  // in the same cycle the FSM decides to read.
  assign rdBus.FIFO_RD_EN = w_pop;
  assign rdBus.RES_DATA   = r_resData;
  assign rdBus.RES_VALID  = r_resValid;
  assign rdBus.RES_LAST   = r_resLast;
  assign FRAME_CNT        = r_frameCnt;
  assign BUSY             = (r_state != ST_IDLE);
  assign ERR_ODD          = r_errOdd;

endmodule

// File: tb/tb_npu_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_npu_fifo_reader
//
// Purpose:
//   Directed self-checking bench for npu_fifo_reader with WORDS_PER_FRAME=4
//   and FRAME_CNT_W=8. A behavioural FIFO with a registered read port feeds
//   the reader; each scenario task drives stimulus and compares outputs
//   against hand-computed values.
// ---------------------------------------------------------------------------
module tb_npu_fifo_reader;
  import npu_fifo_reader_pkg::*;

  logic       CLKEXT = 1'b0;
  logic       RST_GLO;
  logic       EN_RD;
  logic       FLUSH;
  logic [7:0] FRAME_CNT;
  logic       BUSY;
  logic       ERR_ODD;

  int checks = 0;
  int passes = 0;

  npu_fifo_reader_if bus ();

  npu_fifo_reader #(
    .WORDS_PER_FRAME (4),
    .FRAME_CNT_W     (8)
  ) dut (
    .CLKEXT    (CLKEXT),
    .RST_GLO   (RST_GLO),
    .EN_RD     (EN_RD),
    .FLUSH     (FLUSH),
    .rdBus     (bus),
    .FRAME_CNT (FRAME_CNT),
    .BUSY      (BUSY),
    .ERR_ODD   (ERR_ODD)
  );

  always #5 CLKEXT = ~CLKEXT;

  // Behavioural FIFO: bytes are written by the stimulus at negedges, popped
  // at posedges, and data_out is registered (valid the cycle after a pop).
  logic [7:0] mem [0:4095];
  int         pushTotal = 0;
  int         popTotal  = 0;
  int         emptyPops = 0;
  logic [7:0] fifoData  = 8'h00;

  assign bus.FIFO_EMPTY = (pushTotal == popTotal);
  assign bus.FIFO_DATA  = fifoData;

  always @(posedge CLKEXT) begin
    if (bus.FIFO_RD_EN === 1'b1) begin
      if (pushTotal == popTotal) begin
        emptyPops <= emptyPops + 1;
      end else begin
        fifoData <= mem[popTotal[11:0]];
        popTotal <= popTotal + 1;
      end
    end
  end

  // Global watchdog so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushByte(input logic [7:0] b);
    mem[pushTotal[11:0]] = b;
    pushTotal = pushTotal + 1;
  endtask

  // Waits (bounded) for RES_VALID; always advances at least one negedge.
  task automatic waitValid(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLKEXT);
      cyc = cyc + 1;
      if (bus.RES_VALID === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST_GLO       = 1'b1;
    EN_RD         = 1'b0;
    FLUSH         = 1'b0;
    bus.RES_READY = 1'b0;
    repeat (3) @(negedge CLKEXT);
    checks++; if (bus.RES_VALID !== 1'b0) $display("[TB] FAIL rst_valid: got %b, expected 0", bus.RES_VALID); else passes++;
    checks++; if (bus.RES_DATA !== 16'h0000) $display("[TB] FAIL rst_data: got %h, expected 0000", bus.RES_DATA); else passes++;
    checks++; if (bus.RES_LAST !== 1'b0) $display("[TB] FAIL rst_last: got %b, expected 0", bus.RES_LAST); else passes++;
    checks++; if (FRAME_CNT !== 8'd0) $display("[TB] FAIL rst_frame_cnt: got %0d, expected 0", FRAME_CNT); else passes++;
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL rst_busy: got %b, expected 0", BUSY); else passes++;
    checks++; if (ERR_ODD !== 1'b0) $display("[TB] FAIL rst_err_odd: got %b, expected 0", ERR_ODD); else passes++;
    checks++; if (bus.FIFO_RD_EN !== 1'b0) $display("[TB] FAIL rst_rd_en: got %b, expected 0", bus.FIFO_RD_EN); else passes++;
    RST_GLO = 1'b0;
    @(negedge CLKEXT);
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL rst_idle_busy: got %b, expected 0", BUSY); else passes++;
  endtask

  task automatic test_basic();
    int cyc; bit ok; int pop0;
    pushByte(8'h12);
    pushByte(8'h34);
    pop0          = popTotal;
    bus.RES_READY = 1'b1;
    EN_RD         = 1'b1;
    waitValid(cyc, ok);
    EN_RD = 1'b0;
    checks++; if (!ok) $display("[TB] FAIL basic_timeout: got no RES_VALID, expected RES_VALID"); else passes++;
    checks++; if (cyc != 5) $display("[TB] FAIL basic_latency: got %0d, expected 5", cyc); else passes++;
    checks++; if (bus.RES_DATA !== 16'h1234) $display("[TB] FAIL basic_data: got %h, expected 1234", bus.RES_DATA); else passes++;
    checks++; if (bus.RES_LAST !== 1'b0) $display("[TB] FAIL basic_last: got %b, expected 0", bus.RES_LAST); else passes++;
    checks++; if (popTotal - pop0 != 2) $display("[TB] FAIL basic_pops: got %0d, expected 2", popTotal - pop0); else passes++;
    @(negedge CLKEXT);
    checks++; if (bus.RES_VALID !== 1'b0) $display("[TB] FAIL basic_valid_drop: got %b, expected 0", bus.RES_VALID); else passes++;
    checks++; if (FRAME_CNT !== 8'd0) $display("[TB] FAIL basic_frame_cnt: got %0d, expected 0", FRAME_CNT); else passes++;
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL basic_busy: got %b, expected 0", BUSY); else passes++;
  endtask

  task automatic test_empty_stall();
    int cyc; bit ok; int pop0;
    pushByte(8'hAB);
    pop0  = popTotal;
    EN_RD = 1'b1;
    repeat (6) @(negedge CLKEXT);
    checks++; if (popTotal - pop0 != 1) $display("[TB] FAIL stall_pops: got %0d, expected 1", popTotal - pop0); else passes++;
    checks++; if (bus.FIFO_RD_EN !== 1'b0) $display("[TB] FAIL stall_rd_en: got %b, expected 0", bus.FIFO_RD_EN); else passes++;
    checks++; if (BUSY !== 1'b1) $display("[TB] FAIL stall_busy: got %b, expected 1", BUSY); else passes++;
    checks++; if (bus.RES_VALID !== 1'b0) $display("[TB] FAIL stall_valid: got %b, expected 0", bus.RES_VALID); else passes++;
    pushByte(8'hCD);
    waitValid(cyc, ok);
    EN_RD = 1'b0;
    checks++; if (!ok) $display("[TB] FAIL stall_timeout: got no RES_VALID, expected RES_VALID"); else passes++;
    checks++; if (bus.RES_DATA !== 16'hABCD) $display("[TB] FAIL stall_data: got %h, expected abcd", bus.RES_DATA); else passes++;
    checks++; if (bus.RES_LAST !== 1'b0) $display("[TB] FAIL stall_last: got %b, expected 0", bus.RES_LAST); else passes++;
    @(negedge CLKEXT);
  endtask

  // Third and fourth words of the first frame: the fourth carries RES_LAST.
  task automatic test_backpressure();
    int cyc; bit ok; int pop0;
    pushByte(8'h9A);
    pushByte(8'hBC);
    pushByte(8'hDE);
    pushByte(8'hF0);
    bus.RES_READY = 1'b0;
    pop0          = popTotal;
    EN_RD         = 1'b1;
    waitValid(cyc, ok);
    checks++; if (!ok) $display("[TB] FAIL bp_timeout: got no RES_VALID, expected RES_VALID"); else passes++;
    checks++; if (bus.RES_LAST !== 1'b0) $display("[TB] FAIL bp_last: got %b, expected 0", bus.RES_LAST); else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLKEXT);
      checks++; if (bus.RES_VALID !== 1'b1) $display("[TB] FAIL bp_hold_valid: got %b, expected 1", bus.RES_VALID); else passes++;
      checks++; if (bus.RES_DATA !== 16'h9ABC) $display("[TB] FAIL bp_hold_data: got %h, expected 9abc", bus.RES_DATA); else passes++;
      checks++; if (bus.FIFO_RD_EN !== 1'b0) $display("[TB] FAIL bp_no_prefetch: got %b, expected 0", bus.FIFO_RD_EN); else passes++;
    end
    checks++; if (popTotal - pop0 != 2) $display("[TB] FAIL bp_pops: got %0d, expected 2", popTotal - pop0); else passes++;
    bus.RES_READY = 1'b1;
    waitValid(cyc, ok);
    EN_RD = 1'b0;
    checks++; if (!ok) $display("[TB] FAIL b2b_timeout: got no RES_VALID, expected RES_VALID"); else passes++;
    checks++; if (cyc != 5) $display("[TB] FAIL b2b_period: got %0d, expected 5", cyc); else passes++;
    checks++; if (bus.RES_DATA !== 16'hDEF0) $display("[TB] FAIL b2b_data: got %h, expected def0", bus.RES_DATA); else passes++;
    checks++; if (bus.RES_LAST !== 1'b1) $display("[TB] FAIL b2b_last: got %b, expected 1", bus.RES_LAST); else passes++;
    @(negedge CLKEXT);
    checks++; if (FRAME_CNT !== 8'd1) $display("[TB] FAIL b2b_frame_cnt: got %0d, expected 1", FRAME_CNT); else passes++;
    checks++; if (bus.RES_VALID !== 1'b0) $display("[TB] FAIL b2b_valid_drop: got %b, expected 0", bus.RES_VALID); else passes++;
  endtask

  task automatic test_flush_idle();
    FLUSH = 1'b1;
    @(negedge CLKEXT);
    FLUSH = 1'b0;
    @(negedge CLKEXT);
    checks++; if (ERR_ODD !== 1'b0) $display("[TB] FAIL idle_flush_err: got %b, expected 0", ERR_ODD); else passes++;
    checks++; if (FRAME_CNT !== 8'd1) $display("[TB] FAIL idle_flush_frame: got %0d, expected 1", FRAME_CNT); else passes++;
  endtask

  task automatic test_frame();
    int cyc; bit ok; logic [15:0] exp;
    for (int i = 1; i <= 8; i++) pushByte(8'(i));
    bus.RES_READY = 1'b1;
    EN_RD         = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitValid(cyc, ok);
      if (k == 3) EN_RD = 1'b0;
      exp = {8'(2 * k + 1), 8'(2 * k + 2)};
      checks++; if (!ok) $display("[TB] FAIL frame_timeout: got no RES_VALID, expected RES_VALID"); else passes++;
      checks++; if (bus.RES_DATA !== exp) $display("[TB] FAIL frame_data: got %h, expected %h", bus.RES_DATA, exp); else passes++;
      checks++; if (bus.RES_LAST !== (k == 3)) $display("[TB] FAIL frame_last: got %b, expected %b", bus.RES_LAST, (k == 3)); else passes++;
    end
    @(negedge CLKEXT);
    checks++; if (FRAME_CNT !== 8'd2) $display("[TB] FAIL frame_cnt: got %0d, expected 2", FRAME_CNT); else passes++;
  endtask

  // 254 more frames bring the count from 2 to 256, i.e. back to 0.
  task automatic test_frame_wrap();
    int cyc; bit ok; bit abort; int wrapErrs; logic [15:0] exp;
    abort    = 1'b0;
    wrapErrs = 0;
    EN_RD    = 1'b1;
    for (int f = 0; f < 254 && !abort; f++) begin
      for (int i = 0; i < 8; i++) pushByte(8'(f * 3 + i));
      for (int k = 0; k < 4 && !abort; k++) begin
        waitValid(cyc, ok);
        if (f == 253 && k == 3) EN_RD = 1'b0;
        exp = {8'(f * 3 + 2 * k), 8'(f * 3 + 2 * k + 1)};
        if (!ok) begin
          abort    = 1'b1;
          wrapErrs = wrapErrs + 1;
        end else if (bus.RES_DATA !== exp || bus.RES_LAST !== (k == 3)) begin
          wrapErrs = wrapErrs + 1;
        end
      end
    end
    EN_RD = 1'b0;
    @(negedge CLKEXT);
    checks++; if (wrapErrs != 0) $display("[TB] FAIL wrap_words: got %0d bad words, expected 0", wrapErrs); else passes++;
    checks++; if (FRAME_CNT !== 8'd0) $display("[TB] FAIL wrap_frame_cnt: got %0d, expected 0", FRAME_CNT); else passes++;
  endtask

  task automatic test_flush();
    int cyc; bit ok; int pop0; logic [15:0] exp;
    logic [7:0] tail [0:7];
    tail = '{8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pushByte(8'h11);
    pushByte(8'h22);
    bus.RES_READY = 1'b1;
    EN_RD         = 1'b1;
    waitValid(cyc, ok);
    checks++; if (!ok || bus.RES_DATA !== 16'h1122) $display("[TB] FAIL flush_pre_data: got %h, expected 1122", bus.RES_DATA); else passes++;
    pushByte(8'h55);
    pushByte(8'h66);
    pop0 = popTotal;
    repeat (3) @(negedge CLKEXT);
    checks++; if (bus.FIFO_RD_EN !== 1'b1) $display("[TB] FAIL flush_rd_lo_pop: got %b, expected 1", bus.FIFO_RD_EN); else passes++;
    FLUSH = 1'b1;
    EN_RD = 1'b0;
    #1;
    checks++; if (bus.FIFO_RD_EN !== 1'b0) $display("[TB] FAIL flush_rd_en_forced: got %b, expected 0", bus.FIFO_RD_EN); else passes++;
    @(negedge CLKEXT);
    FLUSH = 1'b0;
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL flush_idle: got %b, expected 0", BUSY); else passes++;
    checks++; if (ERR_ODD !== 1'b1) $display("[TB] FAIL flush_err_odd: got %b, expected 1", ERR_ODD); else passes++;
    checks++; if (bus.RES_VALID !== 1'b0) $display("[TB] FAIL flush_valid: got %b, expected 0", bus.RES_VALID); else passes++;
    checks++; if (popTotal - pop0 != 1) $display("[TB] FAIL flush_pops: got %0d, expected 1", popTotal - pop0); else passes++;
    for (int i = 1; i < 8; i++) pushByte(tail[i]);
    EN_RD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitValid(cyc, ok);
      if (k == 3) EN_RD = 1'b0;
      exp = {tail[2 * k], tail[2 * k + 1]};
      checks++; if (!ok || bus.RES_DATA !== exp) $display("[TB] FAIL post_flush_data: got %h, expected %h", bus.RES_DATA, exp); else passes++;
      checks++; if (bus.RES_LAST !== (k == 3)) $display("[TB] FAIL post_flush_last: got %b, expected %b", bus.RES_LAST, (k == 3)); else passes++;
    end
    @(negedge CLKEXT);
    checks++; if (FRAME_CNT !== 8'd1) $display("[TB] FAIL post_flush_frame: got %0d, expected 1", FRAME_CNT); else passes++;
    checks++; if (ERR_ODD !== 1'b1) $display("[TB] FAIL err_odd_sticky: got %b, expected 1", ERR_ODD); else passes++;
  endtask

  task automatic test_reset_midop();
    int cyc; bit ok;
    pushByte(8'h31);
    pushByte(8'h32);
    bus.RES_READY = 1'b0;
    EN_RD         = 1'b1;
    waitValid(cyc, ok);
    EN_RD = 1'b0;
    checks++; if (!ok || bus.RES_DATA !== 16'h3132) $display("[TB] FAIL midop_data: got %h, expected 3132", bus.RES_DATA); else passes++;
    pushByte(8'h41);
    #2 RST_GLO = 1'b1;
    #1;
    checks++; if (bus.RES_VALID !== 1'b0) $display("[TB] FAIL midop_valid: got %b, expected 0", bus.RES_VALID); else passes++;
    checks++; if (bus.RES_DATA !== 16'h0000) $display("[TB] FAIL midop_res_data: got %h, expected 0000", bus.RES_DATA); else passes++;
    checks++; if (bus.RES_LAST !== 1'b0) $display("[TB] FAIL midop_last: got %b, expected 0", bus.RES_LAST); else passes++;
    checks++; if (FRAME_CNT !== 8'd0) $display("[TB] FAIL midop_frame_cnt: got %0d, expected 0", FRAME_CNT); else passes++;
    checks++; if (ERR_ODD !== 1'b0) $display("[TB] FAIL midop_err_odd: got %b, expected 0", ERR_ODD); else passes++;
    checks++; if (BUSY !== 1'b0) $display("[TB] FAIL midop_busy: got %b, expected 0", BUSY); else passes++;
    @(negedge CLKEXT);
    RST_GLO       = 1'b0;
    bus.RES_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLKEXT);
      checks++; if (bus.FIFO_RD_EN !== 1'b0) $display("[TB] FAIL post_rst_rd_en: got %b, expected 0", bus.FIFO_RD_EN); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_stall();
    test_backpressure();
    test_flush_idle();
    test_frame();
    test_frame_wrap();
    test_flush();
    test_reset_midop();
    checks++; if (emptyPops != 0) $display("[TB] FAIL pop_while_empty: got %0d, expected 0", emptyPops); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
